// File: rtl/uart_cmd_initiator_pkg.sv
`default_nettype none
// ============================================================================
// uart_cmd_initiator_pkg : shared command codes, ASCII constants, FSM encodings
// Revision: 1.0
// ============================================================================
package uart_cmd_initiator_pkg;

    // Command codes shared with the command builder
    localparam logic [15:0] COMMAND_WRITE = 16'h0001;
    localparam logic [15:0] COMMAND_READ  = 16'h0002;

    localparam logic [7:0] ASCII_L    = 8'h4C;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] HEX_OFFSET = 8'h37;

    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        TX_IDLE         = 3'd0,
        TX_SEND_START   = 3'd1,
        TX_SEND_COUNT   = 3'd2,
        TX_SEND_COMMAND = 3'd3,
        TX_SEND_ADDRESS = 3'd4,
        TX_WAIT_WR_DATA = 3'd5,
        TX_SEND_DATA    = 3'd6,
        TX_WAIT_RSP     = 3'd7
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE    = 3'd0,
        R_COUNT   = 3'd1,
        R_STATUS  = 3'd2,
        R_ADDRESS = 3'd3,
        R_DATA    = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_initiator_codec.sv
`default_nettype none
// ============================================================================
// hex_ascii_codec : nibble -> uppercase ASCII hex, ASCII hex -> nibble + illegal
// Revision: 1.0
// ============================================================================
module hex_ascii_codec
    import uart_cmd_initiator_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii,
    input  logic [7:0] i_ascii,
    output logic [3:0] o_nibble,
    output logic       o_illegal
);

    always_comb begin
        o_ascii   = (i_nibble < 4'd10) ? (ASCII_0 + {4'h0, i_nibble})
                                       : (HEX_OFFSET + {4'h0, i_nibble});
        o_nibble  = 4'h0;
        o_illegal = 1'b1;
        if (i_ascii >= ASCII_0 && i_ascii <= ASCII_9) begin
            o_nibble  = i_ascii[3:0];
            o_illegal = 1'b0;
        end else if (i_ascii >= ASCII_A && i_ascii <= ASCII_F) begin
            // 'A' has low nibble 1, so +9 lands on 10
            o_nibble  = i_ascii[3:0] + 4'd9;
            o_illegal = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// uart_cmd_initiator : sends 'L' command frames as ASCII hex, parses 'S' replies
// Revision: 1.0
// ============================================================================
module uart_cmd_initiator
    import uart_cmd_initiator_pkg::*;
#(
    parameter logic [31:0] RSP_TIMEOUT = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_stb,
    output logic        o_cmd_ready,
    input  logic [31:0] i_command,
    input  logic [31:0] i_address,
    input  logic [27:0] i_data_count,
    input  logic [31:0] i_wr_data,
    input  logic        i_wr_stb,
    output logic        o_wr_ready,
    output logic [7:0]  o_tx_byte,
    output logic        o_tx_stb,
    input  logic        i_tx_busy,
    input  logic [7:0]  i_rx_byte,
    input  logic        i_rx_stb,
    output logic        o_rsp_stb,
    output logic [31:0] o_rsp_status,
    output logic [31:0] o_rsp_address,
    output logic [31:0] o_rsp_data,
    output logic [27:0] o_rsp_data_count,
    output logic        o_rsp_err,
    output logic [1:0]  o_rsp_err_code
);

    tx_state_t   state_q, state_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [31:0] cmd_q, cmd_d, addr_q, addr_d, shift_q, shift_d;
    logic [27:0] count_q, count_d, words_left_q, words_left_d;
    logic [2:0]  nib_q, nib_d, rx_nib_q, rx_nib_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_stb_q, tx_stb_d;
    logic [27:0] rx_shift_q, rx_shift_d, rx_words_q, rx_words_d;
    logic [31:0] timer_q, timer_d;
    logic        rsp_stb_q, rsp_stb_d, rsp_err_q, rsp_err_d;
    logic [31:0] rsp_status_q, rsp_status_d, rsp_address_q, rsp_address_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [27:0] rsp_count_q, rsp_count_d;
    logic [1:0]  rsp_err_code_q, rsp_err_code_d;

    logic [7:0]  w_tx_ascii;
    logic [3:0]  w_rx_nibble;
    logic        w_rx_illegal;
    logic [31:0] w_rx_word;
    logic        w_send_ok, w_is_write, w_is_read;

    hex_ascii_codec u_codec (
        .i_nibble  (shift_q[31:28]),
        .o_ascii   (w_tx_ascii),
        .i_ascii   (i_rx_byte),
        .o_nibble  (w_rx_nibble),
        .o_illegal (w_rx_illegal)
    );

    // A byte may only go out if the UART is free and we did not strobe last cycle
    assign w_send_ok  = !i_tx_busy && !tx_stb_q;
    assign w_is_write = (cmd_q[15:0] == COMMAND_WRITE);
    assign w_is_read  = (cmd_q[15:0] == COMMAND_READ);
    assign w_rx_word  = {rx_shift_q, w_rx_nibble};

    always_comb begin
        state_d        = state_q;
        rx_state_d     = rx_state_q;
        cmd_d          = cmd_q;
        addr_d         = addr_q;
        count_d        = count_q;
        words_left_d   = words_left_q;
        shift_d        = shift_q;
        nib_d          = nib_q;
        tx_byte_d      = tx_byte_q;
        tx_stb_d       = 1'b0;
        rx_shift_d     = rx_shift_q;
        rx_nib_d       = rx_nib_q;
        rx_words_d     = rx_words_q;
        timer_d        = timer_q;
        rsp_stb_d      = 1'b0;
        rsp_err_d      = 1'b0;
        rsp_err_code_d = rsp_err_code_q;
        rsp_status_d   = rsp_status_q;
        rsp_address_d  = rsp_address_q;
        rsp_data_d     = rsp_data_q;
        rsp_count_d    = rsp_count_q;

        case (state_q)
            TX_IDLE: begin
                if (i_cmd_stb) begin
                    cmd_d        = i_command;
                    addr_d       = i_address;
                    count_d      = i_data_count;
                    words_left_d = (i_command[15:0] == COMMAND_WRITE && i_data_count > 28'd1)
                                 ? i_data_count - 28'd1 : 28'd0;
                    state_d      = TX_SEND_START;
                end
            end
            TX_SEND_START: begin
                if (w_send_ok) begin
                    tx_stb_d  = 1'b1;
                    tx_byte_d = ASCII_L;
                    shift_d   = {count_q, 4'h0};
                    nib_d     = 3'd6;
                    state_d   = TX_SEND_COUNT;
                end
            end
            TX_SEND_COUNT, TX_SEND_COMMAND, TX_SEND_ADDRESS, TX_SEND_DATA: begin
                if (w_send_ok) begin
                    tx_stb_d  = 1'b1;
                    tx_byte_d = w_tx_ascii;
                    shift_d   = {shift_q[27:0], 4'h0};
                    nib_d     = nib_q - 3'd1;
                    if (nib_q == 3'd0) begin
                        nib_d = 3'd7;
                        case (state_q)
                            TX_SEND_COUNT: begin
                                shift_d = cmd_q;
                                state_d = TX_SEND_COMMAND;
                            end
                            TX_SEND_COMMAND: begin
                                shift_d = addr_q;
                                state_d = TX_SEND_ADDRESS;
                            end
                            TX_SEND_ADDRESS: begin
                                shift_d = 32'h0;
                                state_d = w_is_write ? TX_WAIT_WR_DATA : TX_SEND_DATA;
                            end
                            default: begin
                                if (words_left_q == 28'd0) begin
                                    state_d = TX_WAIT_RSP;
                                    timer_d = 32'd0;
                                end else begin
                                    words_left_d = words_left_q - 28'd1;
                                    state_d      = TX_WAIT_WR_DATA;
                                end
                            end
                        endcase
                    end
                end
            end
            TX_WAIT_WR_DATA: begin
                if (i_wr_stb) begin
                    shift_d = i_wr_data;
                    nib_d   = 3'd7;
                    state_d = TX_SEND_DATA;
                end
            end
            TX_WAIT_RSP: begin
                timer_d = timer_q + 32'd1;
                if (i_rx_stb) begin
                    timer_d = 32'd0;
                    if (rx_state_q == R_IDLE) begin
                        if (i_rx_byte == ASCII_S) begin
                            rx_state_d = R_COUNT;
                            rx_nib_d   = 3'd6;
                        end
                    end else if (w_rx_illegal) begin
                        rsp_err_d      = 1'b1;
                        rsp_err_code_d = ERR_ILLEGAL;
                        state_d        = TX_IDLE;
                        rx_state_d     = R_IDLE;
                    end else begin
                        rx_shift_d = w_rx_word[27:0];
                        rx_nib_d   = rx_nib_q - 3'd1;
                        if (rx_nib_q == 3'd0) begin
                            rx_nib_d = 3'd7;
                            case (rx_state_q)
                                R_COUNT: begin
                                    rsp_count_d = w_rx_word[27:0];
                                    rx_words_d  = (w_is_read && w_rx_word[27:0] > 28'd1)
                                                ? w_rx_word[27:0] - 28'd1 : 28'd0;
                                    rx_state_d  = R_STATUS;
                                end
                                R_STATUS: begin
                                    rsp_status_d = w_rx_word;
                                    rx_state_d   = R_ADDRESS;
                                end
                                R_ADDRESS: begin
                                    rsp_address_d = w_rx_word;
                                    rx_state_d    = R_DATA;
                                end
                                default: begin
                                    rsp_data_d = w_rx_word;
                                    rsp_stb_d  = 1'b1;
                                    if (rx_words_q == 28'd0) begin
                                        state_d    = TX_IDLE;
                                        rx_state_d = R_IDLE;
                                    end else begin
                                        rx_words_d = rx_words_q - 28'd1;
                                    end
                                end
                            endcase
                        end
                    end
                end else if (timer_q == RSP_TIMEOUT - 32'd1) begin
                    rsp_err_d      = 1'b1;
                    rsp_err_code_d = ERR_TIMEOUT;
                    state_d        = TX_IDLE;
                    rx_state_d     = R_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // The receiver only listens while a response is outstanding
        if (state_q != TX_WAIT_RSP) begin
            rx_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= TX_IDLE;
            rx_state_q     <= R_IDLE;
            cmd_q          <= '0;
            addr_q         <= '0;
            count_q        <= '0;
            words_left_q   <= '0;
            shift_q        <= '0;
            nib_q          <= '0;
            tx_byte_q      <= '0;
            tx_stb_q       <= 1'b0;
            rx_shift_q     <= '0;
            rx_nib_q       <= '0;
            rx_words_q     <= '0;
            timer_q        <= '0;
            rsp_stb_q      <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_err_code_q <= '0;
            rsp_status_q   <= '0;
            rsp_address_q  <= '0;
            rsp_data_q     <= '0;
            rsp_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            rx_state_q     <= rx_state_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            count_q        <= count_d;
            words_left_q   <= words_left_d;
            shift_q        <= shift_d;
            nib_q          <= nib_d;
            tx_byte_q      <= tx_byte_d;
            tx_stb_q       <= tx_stb_d;
            rx_shift_q     <= rx_shift_d;
            rx_nib_q       <= rx_nib_d;
            rx_words_q     <= rx_words_d;
            timer_q        <= timer_d;
            rsp_stb_q      <= rsp_stb_d;
            rsp_err_q      <= rsp_err_d;
            rsp_err_code_q <= rsp_err_code_d;
            rsp_status_q   <= rsp_status_d;
            rsp_address_q  <= rsp_address_d;
            rsp_data_q     <= rsp_data_d;
            rsp_count_q    <= rsp_count_d;
        end
    end

    assign o_cmd_ready      = (state_q == TX_IDLE);
    assign o_wr_ready       = (state_q == TX_WAIT_WR_DATA);
    assign o_tx_byte        = tx_byte_q;
    assign o_tx_stb         = tx_stb_q;
    assign o_rsp_stb        = rsp_stb_q;
    assign o_rsp_status     = rsp_status_q;
    assign o_rsp_address    = rsp_address_q;
    assign o_rsp_data       = rsp_data_q;
    assign o_rsp_data_count = rsp_count_q;
    assign o_rsp_err        = rsp_err_q;
    assign o_rsp_err_code   = rsp_err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_initiator.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_initiator : directed self-checking bench for uart_cmd_initiator
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_stb, o_cmd_ready;
    logic [31:0] i_command, i_address;
    logic [27:0] i_data_count;
    logic [31:0] i_wr_data;
    logic        i_wr_stb, o_wr_ready;
    logic [7:0]  o_tx_byte;
    logic        o_tx_stb, i_tx_busy;
    logic [7:0]  i_rx_byte;
    logic        i_rx_stb;
    logic        o_rsp_stb;
    logic [31:0] o_rsp_status, o_rsp_address, o_rsp_data;
    logic [27:0] o_rsp_data_count;
    logic        o_rsp_err;
    logic [1:0]  o_rsp_err_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_initiator #(.RSP_TIMEOUT(32'd100)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_cmd_stb        (i_cmd_stb),
        .o_cmd_ready      (o_cmd_ready),
        .i_command        (i_command),
        .i_address        (i_address),
        .i_data_count     (i_data_count),
        .i_wr_data        (i_wr_data),
        .i_wr_stb         (i_wr_stb),
        .o_wr_ready       (o_wr_ready),
        .o_tx_byte        (o_tx_byte),
        .o_tx_stb         (o_tx_stb),
        .i_tx_busy        (i_tx_busy),
        .i_rx_byte        (i_rx_byte),
        .i_rx_stb         (i_rx_stb),
        .o_rsp_stb        (o_rsp_stb),
        .o_rsp_status     (o_rsp_status),
        .o_rsp_address    (o_rsp_address),
        .o_rsp_data       (o_rsp_data),
        .o_rsp_data_count (o_rsp_data_count),
        .o_rsp_err        (o_rsp_err),
        .o_rsp_err_code   (o_rsp_err_code)
    );

    // Monitor: samples on the falling edge, away from the active edge
    int          cyc = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rsp_q[$];
    logic        rsp_ready_q[$];
    logic [1:0]  err_q[$];
    logic        err_ready;
    int          err_cyc, last_tx_cyc;
    logic [31:0] seen_status, seen_address;
    logic [27:0] seen_count;
    logic        busy_prev = 1'b0, stb_prev = 1'b0;
    int          busy_viol = 0, b2b_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_tx_stb) begin
            tx_q.push_back(o_tx_byte);
            last_tx_cyc <= cyc;
            if (busy_prev) busy_viol <= busy_viol + 1;
            if (stb_prev)  b2b_viol  <= b2b_viol + 1;
        end
        if (o_rsp_stb) begin
            rsp_q.push_back(o_rsp_data);
            rsp_ready_q.push_back(o_cmd_ready);
            seen_status  <= o_rsp_status;
            seen_address <= o_rsp_address;
            seen_count   <= o_rsp_data_count;
        end
        if (o_rsp_err) begin
            err_q.push_back(o_rsp_err_code);
            err_ready <= o_cmd_ready;
            err_cyc   <= cyc;
        end
        busy_prev <= i_tx_busy;
        stb_prev  <= o_tx_stb;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic string cat5(input string a, input string b, input string c,
                                   input string d, input string e);
        return {a, b, c, d, e};
    endfunction

    task automatic issue_cmd(input logic [31:0] cmd, input logic [31:0] addr,
                             input logic [27:0] cnt);
        int n = 0;
        tx_q.delete(); rsp_q.delete(); rsp_ready_q.delete(); err_q.delete();
        while (!o_cmd_ready && n < 500) begin tick(1); n++; end
        check("cmd_ready", o_cmd_ready, 1);
        i_command = cmd; i_address = addr; i_data_count = cnt; i_cmd_stb = 1'b1;
        tick(1);
        i_cmd_stb = 1'b0;
    endtask

    task automatic feed_wr(input logic [31:0] d);
        int n = 0;
        while (!o_wr_ready && n < 2000) begin tick(1); n++; end
        check("wr_ready", o_wr_ready, 1);
        i_wr_data = d; i_wr_stb = 1'b1;
        tick(1);
        i_wr_stb = 1'b0;
    endtask

    task automatic wait_bytes(input int want);
        int n = 0;
        while (tx_q.size() < want && n < 3000) begin tick(1); n++; end
        check("byte_count_reached", tx_q.size(), want);
    endtask

    task automatic check_frame(input string tag, input string exp);
        check({tag, "_len"}, tx_q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < tx_q.size()) ? tx_q[i] : 8'h00, exp[i]);
        end
    endtask

    task automatic send_rx(input string s);
        for (int i = 0; i < s.len(); i++) begin
            i_rx_byte = s[i]; i_rx_stb = 1'b1;
            tick(1);
            i_rx_stb = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        int snap;
        int n;
        rst = 1'b1; i_cmd_stb = 0; i_command = 0; i_address = 0; i_data_count = 0;
        i_wr_data = 0; i_wr_stb = 0; i_tx_busy = 0; i_rx_byte = 0; i_rx_stb = 0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        check("rst_cmd_ready", o_cmd_ready, 1);
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_tx_stb", o_tx_stb, 0);
        check("rst_tx_byte", o_tx_byte, 0);
        check("rst_rsp_stb", o_rsp_stb, 0);
        check("rst_rsp_err", o_rsp_err, 0);
        check("rst_rsp_data", o_rsp_data, 0);

        // Write, two words, with the transmitter stalled mid-frame
        issue_cmd(32'h0000_0001, 32'h0000_0100, 28'd2);
        wait_bytes(10);
        i_tx_busy = 1'b1;
        tick(2);
        snap = tx_q.size();
        tick(48);
        check("busy_no_tx", tx_q.size(), snap);
        i_tx_busy = 1'b0;
        feed_wr(32'h1234_5678);
        feed_wr(32'hDEAD_BEEF);
        wait_bytes(40);
        check_frame("wr_frame", "L0000002000000010000010012345678DEADBEEF");
        send_rx(cat5("S", "0000001", "00000000", "00000100", "00000055"));
        check("wr_rsp_count", rsp_q.size(), 1);
        check("wr_rsp_data", (rsp_q.size() > 0) ? rsp_q[0] : 32'hFFFF_FFFF, 32'h55);
        check("wr_idle_after", o_cmd_ready, 1);

        // Read, two response words
        issue_cmd(32'h0000_0002, 32'h0000_0100, 28'd2);
        wait_bytes(32);
        check_frame("rd_frame", cat5("L", "0000002", "00000002", "00000100", "00000000"));
        send_rx("S000000200000002000001000000000A0000000B");
        check("rd_rsp_count", rsp_q.size(), 2);
        check("rd_rsp_data0", (rsp_q.size() > 0) ? rsp_q[0] : 32'hFFFF_FFFF, 32'hA);
        check("rd_rsp_data1", (rsp_q.size() > 1) ? rsp_q[1] : 32'hFFFF_FFFF, 32'hB);
        check("rd_ready_at_word0", (rsp_ready_q.size() > 0) ? rsp_ready_q[0] : 1'bx, 0);
        check("rd_ready_at_word1", (rsp_ready_q.size() > 1) ? rsp_ready_q[1] : 1'bx, 1);
        check("rd_status", seen_status, 32'h2);
        check("rd_address", seen_address, 32'h100);
        check("rd_count", seen_count, 28'd2);

        // Illegal character in the response
        issue_cmd(32'h0000_0002, 32'h0000_0100, 28'd1);
        wait_bytes(32);
        send_rx("S00000x1");
        check("ill_err_count", err_q.size(), 1);
        check("ill_err_code", (err_q.size() > 0) ? err_q[0] : 2'b11, 2'd1);
        check("ill_ready_with_err", err_ready, 1);
        check("ill_no_rsp", rsp_q.size(), 0);

        // No response: timeout after exactly 100 idle cycles
        issue_cmd(32'h0000_0002, 32'h0000_0100, 28'd0);
        wait_bytes(32);
        check_frame("to_frame", cat5("L", "0000000", "00000002", "00000100", "00000000"));
        n = 0;
        while (err_q.size() == 0 && n < 400) begin tick(1); n++; end
        check("to_err_count", err_q.size(), 1);
        check("to_err_code", (err_q.size() > 0) ? err_q[0] : 2'b11, 2'd2);
        check("to_latency", err_cyc - last_tx_cyc, 100);
        check("to_ready", o_cmd_ready, 1);

        // Reset during the address field, then a fresh command
        issue_cmd(32'h0000_0001, 32'h0000_0200, 28'd3);
        wait_bytes(18);
        rst = 1'b1;
        tick(1);
        snap = tx_q.size();
        tick(2);
        rst = 1'b0;
        tick(1);
        check("mr_cmd_ready", o_cmd_ready, 1);
        check("mr_tx_byte", o_tx_byte, 0);
        check("mr_rsp_data", o_rsp_data, 0);
        check("mr_rsp_status", o_rsp_status, 0);
        check("mr_rsp_address", o_rsp_address, 0);
        check("mr_rsp_count", o_rsp_data_count, 0);
        tick(20);
        check("mr_no_tx", tx_q.size(), snap);
        issue_cmd(32'h0000_0001, 32'h0000_0ABC, 28'd1);
        feed_wr(32'hCAFE_0001);
        wait_bytes(32);
        check_frame("mr_frame", cat5("L", "0000001", "00000001", "00000ABC", "CAFE0001"));

        check("tx_while_busy", busy_viol, 0);
        check("tx_back_to_back", b2b_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_initiator.md
UART_CMD_INITIATOR -- requirements
Module: uart_cmd_initiator

Interface
REQ-001 Parameter RSP_TIMEOUT, default 32'd50_000_000; idle clk cycles without a received byte before a response is declared lost.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_cmd_stb  input  1 / o_cmd_ready  output  1  start pulse; accepted only when o_cmd_ready=1.
REQ-005 i_command, i_address  input  32 each; i_data_count  input  28; all sampled on the accepted i_cmd_stb.
REQ-006 i_wr_data  input  32 / i_wr_stb  input  1 / o_wr_ready  output  1  write-word handshake; word taken when i_wr_stb & o_wr_ready.
REQ-007 o_tx_byte  output  8 / o_tx_stb  output  1 / i_tx_busy  input  1  byte stream to UART transmitter.
REQ-008 i_rx_byte  input  8 / i_rx_stb  input  1  byte stream from UART receiver.
REQ-009 o_rsp_stb  output  1  one pulse per received response data word.
REQ-010 o_rsp_status, o_rsp_address, o_rsp_data  output  32 each; o_rsp_data_count  output  28; valid with o_rsp_stb.
REQ-011 o_rsp_err  output  1 / o_rsp_err_code  output  2  error pulse; 1=illegal char, 2=timeout.

Function
REQ-012 Request framing: 'L' (0x4C), 7 hex chars of data_count, 8 of command, 8 of address, then data words of 8 hex chars each; MS nibble first; digits 0x30-0x39, uppercase 0x41-0x46.
REQ-013 Word count sent: write command (command[15:0]==COMMAND_WRITE) sends max(1,data_count) words from the write handshake; every other command sends one word 0x00000000 without the handshake.
REQ-014 o_wr_ready asserts only in WAIT_WR_DATA; one word per handshake; stalls indefinitely while i_wr_stb=0.
REQ-015 o_tx_stb is a one-cycle pulse, issued only when i_tx_busy=0 and o_tx_stb was 0 the previous cycle; o_tx_byte holds until the next pulse.
REQ-016 TX states: IDLE -> SEND_START -> SEND_COUNT(7) -> SEND_COMMAND(8) -> SEND_ADDRESS(8) -> [WAIT_WR_DATA] -> SEND_DATA(8) -> loop or WAIT_RSP -> IDLE.
REQ-017 o_cmd_ready=1 only in IDLE; i_cmd_stb outside IDLE is ignored.
REQ-018 Response framing: 'S' (0x53), 7 chars count, 8 status, 8 address, 8 data, then max(1,count)-1 further 8-char data words from a read; all other commands expect one word.
REQ-019 RX states: R_IDLE (discard non-'S') -> R_COUNT -> R_STATUS -> R_ADDRESS -> R_DATA(repeat); active only while TX is in WAIT_RSP.
REQ-020 o_rsp_stb pulses one cycle after the 8th nibble of each data word; status/address/count stay stable for the whole response.
REQ-021 After the last expected word: TX WAIT_RSP -> IDLE in the same cycle as o_rsp_stb.
REQ-022 Illegal char (not 0-9/A-F) after 'S': o_rsp_err pulse, code 1; both FSMs -> IDLE.
REQ-023 Timeout counter clears on each i_rx_stb and on entering WAIT_RSP; at RSP_TIMEOUT: o_rsp_err pulse, code 2, -> IDLE.
REQ-024 i_rx_stb outside WAIT_RSP is discarded; simultaneous error and last word: error wins, no o_rsp_stb.

Reset
REQ-025 On rst: both FSMs IDLE, counters 0, all pulse outputs 0, data/status outputs 0, o_tx_byte 0, o_cmd_ready 1 the cycle after rst deasserts.
REQ-026 rst mid-frame aborts immediately; no further o_tx_stb, no partial o_rsp_stb.

Structure
REQ-027 COMMAND_WRITE/COMMAND_READ come from cbuilder_defines.v; the ASCII constants ('L','S','0','A', hex offset 0x37) belong in the shared defines.
REQ-028 One sub-module, hex_ascii_codec: combinational nibble->ASCII and ASCII->nibble+illegal flag.

Verification
REQ-029 Write, cmd 0x00000001, addr 0x100, count 2, data 0x12345678,0xDEADBEEF -> bytes "L0000002000000010000010012345678DEADBEEF".
REQ-030 Read, count 2; feed "S000000200000002000001000000000A0000000B" -> two o_rsp_stb, data 0xA then 0xB, status 0x2, address 0x100.
REQ-031 i_tx_busy held high 50 cycles mid-frame -> no o_tx_stb while busy; byte sequence unchanged.
REQ-032 Response "S00000x1..." -> o_rsp_err, code 1; o_cmd_ready=1 next cycle.
REQ-033 RSP_TIMEOUT=100, no response -> o_rsp_err code 2 exactly 100 cycles after WAIT_RSP entry.
REQ-034 rst asserted during SEND_ADDRESS -> no further o_tx_stb; new command after reset framed correctly.
